matrix_owner_arb: RTL

- Time-shared arbiter for the 5x7 LED matrix row/column drive.
- Replaces the OR-merge of per-mode row/column outputs: several pattern sources (test pattern, scan light, later modes) request the matrix, and exactly one owns it at a time.
- Round-robin time slices, with a forced blanking gap on every ownership change to prevent ghosting.
- Sits between the mode modules and the top-level row/column pins.

---
 rtl/matrix_pkg.sv | 16 +
 rtl/rr_pick.sv | 31 +++
 rtl/matrix_owner_arb.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/matrix_pkg.sv
// Shared constants and types for the LED matrix owner arbiter.
// The slice and blank defaults assume a 50 MHz CLOCK_50.
package matrix_pkg;

    localparam int ROWS          = 5;
    localparam int COLS          = 7;
    localparam int DEF_SLICE_CYC = 50000;  // 1 ms ownership slice
    localparam int DEF_BLANK_CYC = 500;    // 10 us all-off gap

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        OWN   = 2'd2
    } state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector.
// Scans req upward from ptr, wrapping modulo N_SRC; the first set bit wins.
module rr_pick #(
    parameter int N_SRC = 4,
    parameter int PTR_W = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
    input  logic [N_SRC-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N_SRC-1:0] winner,
    output logic             valid
);

    always_comb begin
        int               idx;
        logic [PTR_W-1:0] sel;
        // NOTE: every output gets a default before the loop, so no path leaves it unassigned and no latch is inferred.
        winner = '0;
        valid  = 1'b0;
        idx    = 0;
        sel    = '0;
        for (int off = 0; off < N_SRC; off++) begin
            idx = (int'(ptr) + off) % N_SRC;
            sel = PTR_W'(idx);
            if (!valid && req[sel]) begin
                winner[sel] = 1'b1;
                valid       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/matrix_owner_arb.sv
// Time-shared owner of the 5x7 matrix row/column drive.
// Round-robin slices between requesting pattern sources, with an all-off gap on every ownership change.
module matrix_owner_arb
    import matrix_pkg::*;
#(
    parameter int N_SRC     = 4,
    parameter int ROWS      = matrix_pkg::ROWS,
    parameter int COLS      = matrix_pkg::COLS,
    parameter int SLICE_CYC = DEF_SLICE_CYC,
    parameter int BLANK_CYC = DEF_BLANK_CYC
) (
    input  logic                  CLOCK_50,
    input  logic                  reset,
    input  logic [N_SRC-1:0]      req,
    input  logic [N_SRC*ROWS-1:0] src_row,
    input  logic [N_SRC*COLS-1:0] src_col,
    output logic [N_SRC-1:0]      grant,
    output logic [ROWS-1:0]       row,
    output logic [COLS-1:0]       column,
    output logic                  busy
);

    localparam int PTR_W  = (N_SRC > 1) ? $clog2(N_SRC) : 1;
    localparam int SCNT_W = $clog2(SLICE_CYC + 1);
    localparam int BCNT_W = $clog2(BLANK_CYC + 1);

    localparam logic [SCNT_W-1:0] SLICE_LAST = SCNT_W'(SLICE_CYC - 1);
    localparam logic [BCNT_W-1:0] BLANK_LAST = BCNT_W'(BLANK_CYC - 1);
    localparam logic [PTR_W-1:0]  PTR_LAST   = PTR_W'(N_SRC - 1);

    state_t              state_q, state_d;
    logic [N_SRC-1:0]    grant_q, grant_d;
    logic [PTR_W-1:0]    owner_q, owner_d;
    logic [PTR_W-1:0]    ptr_q, ptr_d;
    logic [SCNT_W-1:0]   slice_q, slice_d;
    logic [BCNT_W-1:0]   blank_q, blank_d;
    logic [ROWS-1:0]     row_q, row_d;
    logic [COLS-1:0]     col_q, col_d;
    logic                busy_q, busy_d;

    logic [N_SRC-1:0]    pick_onehot;
    logic                pick_valid;
    logic [PTR_W-1:0]    pick_idx;
    logic [PTR_W-1:0]    pick_next_ptr;
    logic                owner_req;
    logic                others_req;
    logic [ROWS-1:0]     owner_row;
    logic [COLS-1:0]     owner_col;

    rr_pick #(
        .N_SRC (N_SRC),
        .PTR_W (PTR_W)
    ) u_rr_pick (
        .req    (req),
        .ptr    (ptr_q),
        .winner (pick_onehot),
        .valid  (pick_valid)
    );

    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (pick_onehot[i]) pick_idx = PTR_W'(i);
        end
        pick_next_ptr = (pick_idx == PTR_LAST) ? '0 : pick_idx + PTR_W'(1);
    end

    assign owner_req  = req[owner_q];
    assign others_req = |(req & ~grant_q);
    assign owner_row  = src_row[owner_q*ROWS +: ROWS];
    assign owner_col  = src_col[owner_q*COLS +: COLS];

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        slice_d = slice_q;
        blank_d = blank_q;
        row_d   = row_q;
        col_d   = col_q;

        unique case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d = OWN;
                    grant_d = pick_onehot;
                    owner_d = pick_idx;
                    ptr_d   = pick_next_ptr;
                    slice_d = '0;
                end
            end

            OWN: begin
                // An owner dropping its request takes precedence over slice expiry.
                if (!owner_req || (slice_q == SLICE_LAST && others_req)) begin
                    state_d = BLANK;
                    grant_d = '0;
                    row_d   = '0;
                    col_d   = '0;
                    blank_d = '0;
                end else begin
                    slice_d = (slice_q == SLICE_LAST) ? '0 : slice_q + SCNT_W'(1);
                    row_d   = owner_row;
                    col_d   = owner_col;
                end
            end

            BLANK: begin
                if (blank_q == BLANK_LAST) begin
                    blank_d = '0;
                    if (pick_valid) begin
                        state_d = OWN;
                        grant_d = pick_onehot;
                        owner_d = pick_idx;
                        ptr_d   = pick_next_ptr;
                        slice_d = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    blank_d = blank_q + BCNT_W'(1);
                end
            end

            default: begin
                state_d = IDLE;
                grant_d = '0;
                row_d   = '0;
                col_d   = '0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples the pre-edge values.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q <= IDLE;
            grant_q <= '0;
            owner_q <= '0;
            ptr_q   <= '0;
            slice_q <= '0;
            blank_q <= '0;
            row_q   <= '0;
            col_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            slice_q <= slice_d;
            blank_q <= blank_d;
            row_q   <= row_d;
            col_q   <= col_d;
            busy_q  <= busy_d;
        end
    end

    assign grant  = grant_q;
    assign row    = row_q;
    assign column = col_q;
    assign busy   = busy_q;

endmodule
